// File: rtl/upd_slowphy_pkg.sv
// Shared constants and FSM encoding for the slow-PHY IQ/noise packer.
package upd_slowphy_pkg;
  localparam int LANE_W   = 16;
  localparam int LANES    = 8;
  localparam int FIFO_W   = LANE_W * LANES;
  localparam int IQ_PUSH  = 4;
  localparam int NZ_PUSH  = 1;

  typedef enum logic [1:0] {IDLE, PACK, FLUSH, DONE} state_t;
endpackage

// File: rtl/upd_lane_packer.sv
// Generic LANES-lane accumulator: PUSH lanes per push, pending word reg, full-gated write,
// zero-pad flush of a partial word.
module upd_lane_packer #(
  parameter int LANE_W = 16,
  parameter int LANES  = 8,
  parameter int PUSH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          push,
  input  logic [PUSH-1:0][LANE_W-1:0]   push_data,
  input  logic                          flush,
  input  logic                          full,
  output logic                          we,
  output logic [LANES-1:0][LANE_W-1:0]  wdata,
  output logic                          pend,
  output logic                          empty
);
  localparam int PW = $clog2(LANES);

  logic [LANES-1:0][LANE_W-1:0] acc, acc_nxt;
  logic [PW-1:0]                ptr;
  logic                         complete, do_flush;

  always_comb begin
    acc_nxt = acc;
    for (int l = 0; l < LANES; l++)
      for (int k = 0; k < PUSH; k++)
        if (int'(ptr) + k == l) acc_nxt[l] = push_data[k];
  end

  assign complete = push && (int'(ptr) + PUSH == LANES);
  // Unused lanes of acc are always zero, so a flushed partial word is already padded.
  assign do_flush = flush && !push && (ptr != '0) && !pend;
  assign empty    = (ptr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      ptr   <= '0;
      wdata <= '0;
      we    <= 1'b0;
      pend  <= 1'b0;
    end else begin
      we <= 1'b0;
      if (pend && !full) begin
        we   <= 1'b1;
        pend <= 1'b0;
      end
      if (clr) begin
        acc <= '0;
        ptr <= '0;
      end else if (complete || do_flush) begin
        wdata <= complete ? acc_nxt : acc;
        acc   <= '0;
        ptr   <= '0;
        if (full) pend <= 1'b1;
        else      we   <= 1'b1;
      end else if (push) begin
        acc <= acc_nxt;
        ptr <= ptr + PW'(PUSH);
      end
    end
  end
endmodule

// File: rtl/upd_slowphy_iq_noise_packer.sv
// Write side of the slow-PHY IQ/noise FIFO pair: packs RE pairs and noise samples into
// 8-lane words. Optional UPD_PACKER_DROP_CNT_EN adds a saturating dropped-input counter.
module upd_slowphy_iq_noise_packer
  import upd_slowphy_pkg::*;
#(
  parameter int LANE_W = upd_slowphy_pkg::LANE_W,
  parameter int LANES  = upd_slowphy_pkg::LANES
) (
  input  logic                     i_core_clk,
  input  logic                     i_rx_rstn,
  input  logic                     i_frame_start,
  input  logic [15:0]              i_cur_user_re_amounts,
  input  logic                     i_data_strobe,
  input  logic [LANE_W-1:0]        i_re0_data_i,
  input  logic [LANE_W-1:0]        i_re0_data_q,
  input  logic [LANE_W-1:0]        i_re1_data_i,
  input  logic [LANE_W-1:0]        i_re1_data_q,
  input  logic                     i_noise_valid,
  input  logic [LANE_W-1:0]        i_noise_data,
  output logic                     o_ready,
  input  logic                     IQ_FIFO_Full,
  input  logic                     Noise_FIFO_Full,
  output logic                     IQ_FIFO_Write_Enable,
  output logic [LANE_W*LANES-1:0]  IQ_Data_SUM,
  output logic                     Noise_FIFO_Write_Enable,
  output logic [LANE_W*LANES-1:0]  Noise_Data_SUM,
  output logic                     o_frame_done,
`ifdef UPD_PACKER_DROP_CNT_EN
  output logic [15:0]              o_drop_cnt,
`endif
  output logic                     o_drop_err
);
  state_t                        state;
  logic [15:0]                   re_amount, re_cnt, re_cnt_nxt;
  logic                          last_odd, strobe_acc, noise_acc, drop, clr, drained;
  logic [IQ_PUSH-1:0][LANE_W-1:0] iq_push;
  logic [NZ_PUSH-1:0][LANE_W-1:0] nz_push;
  logic [LANES-1:0][LANE_W-1:0]  iq_word, nz_word;
  logic                          iq_pend, nz_pend, iq_empty, nz_empty;

  assign o_ready    = (state == PACK) && !iq_pend && !nz_pend;
  assign strobe_acc = i_data_strobe && o_ready;
  assign noise_acc  = i_noise_valid && o_ready;
  assign drop       = ((i_data_strobe || i_noise_valid) && !o_ready) ||
                      (i_frame_start && state != IDLE);
  assign clr        = (state == IDLE) && i_frame_start;

  // A single remaining RE takes only re0; re1 lanes are zeroed and the count saturates.
  assign last_odd   = (re_amount - re_cnt) == 16'd1;
  assign re_cnt_nxt = last_odd ? re_amount : re_cnt + 16'd2;

  assign iq_push[0] = i_re0_data_i;
  assign iq_push[1] = i_re0_data_q;
  assign iq_push[2] = last_odd ? '0 : i_re1_data_i;
  assign iq_push[3] = last_odd ? '0 : i_re1_data_q;
  assign nz_push[0] = i_noise_data;

  upd_lane_packer #(.LANE_W(LANE_W), .LANES(LANES), .PUSH(IQ_PUSH)) u_iq (
    .clk(i_core_clk), .rst_n(i_rx_rstn), .clr(clr), .push(strobe_acc), .push_data(iq_push),
    .flush(state == FLUSH), .full(IQ_FIFO_Full), .we(IQ_FIFO_Write_Enable),
    .wdata(iq_word), .pend(iq_pend), .empty(iq_empty)
  );

  upd_lane_packer #(.LANE_W(LANE_W), .LANES(LANES), .PUSH(NZ_PUSH)) u_nz (
    .clk(i_core_clk), .rst_n(i_rx_rstn), .clr(clr), .push(noise_acc), .push_data(nz_push),
    .flush(state == FLUSH), .full(Noise_FIFO_Full), .we(Noise_FIFO_Write_Enable),
    .wdata(nz_word), .pend(nz_pend), .empty(nz_empty)
  );

  assign IQ_Data_SUM    = iq_word;
  assign Noise_Data_SUM = nz_word;

  // Frame is finished only once both accumulators are empty and the last write has gone out.
  assign drained = iq_empty && nz_empty && !iq_pend && !nz_pend &&
                   !IQ_FIFO_Write_Enable && !Noise_FIFO_Write_Enable;

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state        <= IDLE;
      re_amount    <= '0;
      re_cnt       <= '0;
      o_frame_done <= 1'b0;
      o_drop_err   <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      if (drop) o_drop_err <= 1'b1;
      case (state)
        IDLE: if (i_frame_start) begin
          re_amount <= i_cur_user_re_amounts;
          re_cnt    <= '0;
          state     <= (i_cur_user_re_amounts == 16'd0) ? FLUSH : PACK;
        end
        PACK: if (strobe_acc) begin
          re_cnt <= re_cnt_nxt;
          if (re_cnt_nxt >= re_amount) state <= FLUSH;
        end
        FLUSH: if (drained) begin
          state        <= DONE;
          o_frame_done <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UPD_PACKER_DROP_CNT_EN
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn)              o_drop_cnt <= '0;
    else if (clr)                o_drop_cnt <= drop ? 16'd1 : 16'd0;
    else if (drop && o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_upd_slowphy_iq_noise_packer.sv
// Scoreboard bench: stimulus pushes expected FIFO words, a negedge monitor pops and compares.
module tb_upd_slowphy_iq_noise_packer;
  logic         clk = 1'b0;
  logic         rstn;
  logic         frame_start, strobe, noise_valid, iq_full, nz_full;
  logic [15:0]  amounts, re0_i, re0_q, re1_i, re1_q, noise_data;
  logic         ready, iq_we, nz_we, frame_done, drop_err;
  logic [127:0] iq_data, nz_data;
`ifdef UPD_PACKER_DROP_CNT_EN
  logic [15:0]  drop_cnt;
`endif

  always #5 clk = ~clk;

  upd_slowphy_iq_noise_packer dut (
    .i_core_clk(clk), .i_rx_rstn(rstn), .i_frame_start(frame_start),
    .i_cur_user_re_amounts(amounts), .i_data_strobe(strobe),
    .i_re0_data_i(re0_i), .i_re0_data_q(re0_q), .i_re1_data_i(re1_i), .i_re1_data_q(re1_q),
    .i_noise_valid(noise_valid), .i_noise_data(noise_data), .o_ready(ready),
    .IQ_FIFO_Full(iq_full), .Noise_FIFO_Full(nz_full),
    .IQ_FIFO_Write_Enable(iq_we), .IQ_Data_SUM(iq_data),
    .Noise_FIFO_Write_Enable(nz_we), .Noise_Data_SUM(nz_data),
    .o_frame_done(frame_done),
`ifdef UPD_PACKER_DROP_CNT_EN
    .o_drop_cnt(drop_cnt),
`endif
    .o_drop_err(drop_err)
  );

  logic [127:0] iq_q[$], nz_q[$];
  int vec = 0, err = 0, done_pend = 0, done_seen = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (iq_we === 1'b1) begin
      if (iq_q.size() == 0) begin
        vec++; err++;
        $display("FAIL iq_unexpected_write: got %h expected no write", iq_data);
      end else chk("iq_word", iq_data, iq_q.pop_front());
    end
    if (nz_we === 1'b1) begin
      if (nz_q.size() == 0) begin
        vec++; err++;
        $display("FAIL nz_unexpected_write: got %h expected no write", nz_data);
      end else chk("nz_word", nz_data, nz_q.pop_front());
    end
    if (frame_done === 1'b1) begin
      vec++; done_seen++;
      if (done_pend == 0 || iq_q.size() != 0 || nz_q.size() != 0) begin
        err++;
        $display("FAIL frame_done: got pulse with %0d iq / %0d nz words outstanding, expected %0d pending frames and none outstanding",
                 iq_q.size(), nz_q.size(), done_pend);
      end else done_pend--;
    end
  end

  task automatic wait_ready(input string name);
    int t = 0;
    while (!ready && t < 200) begin @(posedge clk); #1; t++; end
    if (!ready) begin
      vec++; err++;
      $display("FAIL %s_ready_timeout: got ready=0 expected ready=1", name);
    end
  endtask

  task automatic start_frame(input logic [15:0] n);
    amounts = n; frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic send_strobe(input logic [15:0] a, b, c, d);
    wait_ready("strobe");
    re0_i = a; re0_q = b; re1_i = c; re1_q = d; strobe = 1'b1;
    @(posedge clk); #1;
    strobe = 1'b0;
  endtask

  task automatic send_noise(input logic [15:0] v);
    wait_ready("noise");
    noise_data = v; noise_valid = 1'b1;
    @(posedge clk); #1;
    noise_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int s = done_seen;
    int t = 0;
    while (done_seen == s && t < 3000) begin @(posedge clk); #1; t++; end
    vec++;
    if (done_seen == s) begin
      err++;
      $display("FAIL %s_done_timeout: got no frame_done expected one", name);
    end
  endtask

  initial begin
    logic [127:0] w;
    rstn = 1'b0; frame_start = 0; strobe = 0; noise_valid = 0; iq_full = 0; nz_full = 0;
    amounts = 0; re0_i = 0; re0_q = 0; re1_i = 0; re1_q = 0; noise_data = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_ready", ready, 0);
    chk("rst_iq_we", iq_we, 0);
    chk("rst_iq_data", iq_data, 0);
    chk("rst_nz_data", nz_data, 0);
    chk("rst_drop_err", drop_err, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // 6 REs: second word zero-padded in lanes 4..7
    iq_q.push_back(128'h0107_0106_0105_0104_0103_0102_0101_0100);
    iq_q.push_back(128'h0000_0000_0000_0000_010B_010A_0109_0108);
    done_pend++;
    start_frame(16'd6);
    send_strobe(16'h0100, 16'h0101, 16'h0102, 16'h0103);
    send_strobe(16'h0104, 16'h0105, 16'h0106, 16'h0107);
    send_strobe(16'h0108, 16'h0109, 16'h010A, 16'h010B);
    wait_done("six");

    // 5 REs: re1 of the third strobe must be written as zero
    iq_q.push_back(128'h0207_0206_0205_0204_0203_0202_0201_0200);
    iq_q.push_back(128'h0000_0000_0000_0000_0000_0000_0209_0208);
    done_pend++;
    start_frame(16'd5);
    send_strobe(16'h0200, 16'h0201, 16'h0202, 16'h0203);
    send_strobe(16'h0204, 16'h0205, 16'h0206, 16'h0207);
    send_strobe(16'h0208, 16'h0209, 16'h020A, 16'h020B);
    wait_done("five");
    chk("no_drop_yet", drop_err, 0);

    // One full noise word plus a single strobe flushed as a padded IQ word
    nz_q.push_back(128'h0077_0066_0055_0044_0033_0022_0011_000C);
    iq_q.push_back(128'h0000_0000_0000_0000_0303_0302_0301_0300);
    done_pend++;
    start_frame(16'd2);
    send_noise(16'h000C); send_noise(16'h0011); send_noise(16'h0022); send_noise(16'h0033);
    send_noise(16'h0044); send_noise(16'h0055); send_noise(16'h0066); send_noise(16'h0077);
    send_strobe(16'h0300, 16'h0301, 16'h0302, 16'h0303);
    wait_done("noise");

    // Noise FIFO full at word completion for 39 cycles, one strobe dropped meanwhile
    nz_q.push_back(128'h00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0);
    iq_q.push_back(128'h0000_0000_0000_0000_0403_0402_0401_0400);
    done_pend++;
    start_frame(16'd2);
    nz_full = 1'b1;
    for (int k = 0; k < 8; k++) send_noise(16'h00A0 + 16'(k));
    for (int i = 0; i < 39; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      re0_i = 16'hDEAD; re0_q = 16'hDEAD; re1_i = 16'hDEAD; re1_q = 16'hDEAD;
      strobe = (i == 2);
      @(negedge clk);
      chk("stall_ready", ready, 0);
      chk("stall_we", nz_we, 0);
      chk("stall_data", nz_data, 128'h00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0);
    end
    @(posedge clk); #1;
    nz_full = 1'b0; strobe = 1'b0;
    @(negedge clk);
    chk("release_we_same_cycle", nz_we, 0);
    @(negedge clk);
    chk("release_we_next_cycle", nz_we, 1);
    chk("drop_err_set", drop_err, 1);
`ifdef UPD_PACKER_DROP_CNT_EN
    chk("drop_cnt", drop_cnt, 16'd1);
`endif
    @(posedge clk); #1;
    send_strobe(16'h0400, 16'h0401, 16'h0402, 16'h0403);
    wait_done("stall");

    // 1800 REs -> 450 words, lane l of word w carries 8w+l
    for (int wi = 0; wi < 450; wi++) begin
      for (int l = 0; l < 8; l++) w[l*16 +: 16] = 16'(8*wi + l);
      iq_q.push_back(w);
    end
    done_pend++;
    start_frame(16'd1800);
    for (int n = 0; n < 900; n++)
      send_strobe(16'(4*n), 16'(4*n+1), 16'(4*n+2), 16'(4*n+3));
    wait_done("long");

    // Reset mid-frame: the completed first word is written, the partial one is discarded
    iq_q.push_back(128'h0507_0506_0505_0504_0503_0502_0501_0500);
    start_frame(16'd100);
    send_strobe(16'h0500, 16'h0501, 16'h0502, 16'h0503);
    send_strobe(16'h0504, 16'h0505, 16'h0506, 16'h0507);
    send_strobe(16'h0508, 16'h0509, 16'h050A, 16'h050B);
    rstn = 1'b0;
    #1;
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_iq_we", iq_we, 0);
    chk("mid_rst_nz_we", nz_we, 0);
    chk("mid_rst_iq_data", iq_data, 0);
    chk("mid_rst_done", frame_done, 0);
    chk("mid_rst_drop_err", drop_err, 0);
    repeat (3) @(posedge clk); #1;
    rstn = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("post_rst_ready", ready, 0);

    vec++;
    if (iq_q.size() != 0 || nz_q.size() != 0 || done_pend != 0) begin
      err++;
      $display("FAIL drain: got %0d iq %0d nz %0d frames outstanding expected 0",
               iq_q.size(), nz_q.size(), done_pend);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
